// File: rtl/mac_accum_stage.sv
// ---------------------------------------------------------------------------
// mac_accum_stage
//
// Accumulate stage that sits behind the 16x16 multiplier. Signed products are
// taken over a valid/ready handshake and DOT_LEN of them are summed into a
// signed ACC_W-bit accumulator. Each finished sum is then offered downstream
// over a second valid/ready handshake, together with a sticky overflow flag.
//
// Optional feature macro: MAC_SATURATE_EN
//   defined   : on overflow the accumulator clamps to the most positive or
//               most negative ACC_W-bit value.
//   undefined : two's-complement wrap; no clamp logic is built.
//
// Ports:
//   sys_clk    in   1       system clock, rising edge
//   sys_rst_n  in   1       asynchronous active-low reset
//   in_valid   in   1       in_prod is valid this cycle
//   in_ready   out  1       stage can accept a product (combinational on in_clr)
//   in_prod    in   PROD_W  signed product
//   in_clr     in   1       synchronous clear, aborts the current sum
//   acc_valid  out  1       acc_out/acc_ovf hold a finished result
//   acc_ready  in   1       downstream accepts the result
//   acc_out    out  ACC_W   signed dot-product result
//   acc_ovf    out  1       overflow occurred during this result
// ---------------------------------------------------------------------------
module mac_accum_stage #(
  parameter int PROD_W  = 32,
  parameter int ACC_W   = 40,
  parameter int DOT_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_clr,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_ovf
);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DOT_LEN - 1);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic               acc_ovf_q, acc_ovf_d;
  logic               acc_valid_q, acc_valid_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum_raw;
  logic [ACC_W-1:0]   sum_next;
  logic               add_ovf;

  // Sign-extend the product to accumulator width.
  assign prod_ext = ACC_W'($signed(in_prod));
  assign sum_raw  = acc_q + prod_ext;
  // Same-sign operands whose sum flips sign have overflowed.
  assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);

  assign in_ready  = (state_q == ST_ACC) && !in_clr;
  assign acc_valid = acc_valid_q;
  assign acc_out   = acc_out_q;
  assign acc_ovf   = acc_ovf_q;

  // Overflow handling: clamp toward the operands' sign, or plain wrap.
  always_comb begin
    sum_next = sum_raw;
`ifdef MAC_SATURATE_EN
    if (add_ovf) begin
      if (acc_q[ACC_W-1]) begin
        sum_next = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sum_next = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      sum_next = sum_raw;
    end
`else
    sum_next = sum_raw;
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    acc_out_d   = acc_out_q;
    acc_ovf_d   = acc_ovf_q;
    acc_valid_d = acc_valid_q;
    if (in_clr) begin
      // Clear outranks everything except reset and drops any pending result.
      state_d     = ST_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      acc_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            if (cnt_q == LAST_CNT) begin
              acc_out_d   = sum_next;
              acc_ovf_d   = ovf_q | add_ovf;
              acc_valid_d = 1'b1;
              state_d     = ST_OUT;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_d       = 1'b0;
            end else begin
              acc_d = sum_next;
              cnt_d = cnt_q + CNT_W'(1);
              ovf_d = ovf_q | add_ovf;
            end
          end else begin
            state_d = ST_ACC;
          end
        end
        ST_OUT: begin
          if (acc_ready) begin
            acc_valid_d = 1'b0;
            state_d     = ST_ACC;
          end else begin
            state_d = ST_OUT;
          end
        end
        default: begin
          state_d     = ST_ACC;
          acc_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      acc_out_q   <= '0;
      acc_ovf_q   <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      acc_out_q   <= acc_out_d;
      acc_ovf_q   <= acc_ovf_d;
      acc_valid_q <= acc_valid_d;
    end
  end

endmodule

// File: doc/mac_accum_stage.md
Name: mac_accum_stage

Overview:
- Sequential accumulate stage placed directly downstream of the combinational 16x16 Booth-4/Wallace multiplier `mult_16_16_top`.
- Takes the signed 32-bit product C_NUM through a valid/ready handshake and sums DOT_LEN products into a signed ACC_W-bit accumulator.
- Presents each finished dot-product result with a valid/ready handshake to the next stage, and reports overflow.

Parameters:
- PROD_W, 32: width of the signed product input. Matches C_NUM.
- ACC_W, 40: width of the signed accumulator and result. Must be >= PROD_W.
- DOT_LEN, 8: number of products summed per result. Must be >= 1.
- CNT_W, 8: width of the beat counter. Must satisfy 2^CNT_W > DOT_LEN.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_prod is valid this cycle.
- in_ready  out  1  stage can accept a product this cycle.
- in_prod  in  PROD_W  signed product (from C_NUM).
- in_clr  in  1  synchronous clear: abort the current sum.
- acc_valid  out  1  acc_out/acc_ovf hold a finished result.
- acc_ready  in  1  downstream accepts the result.
- acc_out  out  ACC_W  signed dot-product result.
- acc_ovf  out  1  overflow occurred during this result's accumulation.

Behaviour:
- Reset (sys_rst_n low, asynchronous):
  - state=ACC; internal acc=0; cnt=0; ovf=0.
  - acc_valid=0, acc_out=0, acc_ovf=0.
  - in_ready takes its combinational value in ACC, i.e. 1 unless in_clr is high.
  - Asserting reset mid-sum or mid-handshake discards everything.
- Beat accept: a product is accepted when in_valid && in_ready at a rising edge. in_prod is sign-extended to ACC_W before addition.
- in_ready = (state==ACC) && !in_clr. This is combinational on in_clr; no other combinational input-to-output paths exist.
- State ACC:
  - Each accepted beat: acc <= acc + sext(in_prod); cnt <= cnt+1; ovf <= ovf | add_overflow.
  - On the beat where cnt==DOT_LEN-1:
    - acc_out <= final sum; acc_ovf <= final ovf; acc_valid <= 1; state <= OUT.
    - acc, cnt and ovf are reset to 0 for the next sum.
  - Latency: acc_valid rises 1 cycle after the last beat is accepted.
- State OUT:
  - in_ready=0.
  - acc_out, acc_ovf and acc_valid are held stable until acc_valid && acc_ready at a rising edge.
  - On that edge: acc_valid <= 0, state <= ACC. in_ready becomes 1 the following cycle.
  - Net throughput: DOT_LEN beats plus at least 1 bubble per result.
- add_overflow: both operands have the same sign and the ACC_W-bit sum's sign differs from them.
- Without the optional feature the sum wraps modulo 2^ACC_W. The overflow flag is sticky per result and never reset by a later in-range sum.
- in_clr (synchronous, highest priority below reset):
  - acc=0, cnt=0, ovf=0, acc_valid=0, state=ACC.
  - Any pending result in OUT is dropped.
  - A beat presented with in_clr high is not accepted, since in_ready=0.
- in_valid while in OUT is ignored; the upstream must hold the beat.
- acc_ready while in ACC is ignored.
- DOT_LEN=1: every accepted beat produces a result; the OUT bubble still applies.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined: on add_overflow the accumulator clamps to +(2^(ACC_W-1)-1) for a positive overflow, or -(2^(ACC_W-1)) for a negative one. Later beats of the same sum continue from the clamped value with the same clamp rule. acc_ovf is set exactly as in wrap mode.
- Undefined: two's-complement wrap, as described in Behaviour. No saturation logic is synthesised.

Test Plan:
- Reset: pulse sys_rst_n low mid-sum after 3 beats -> acc_valid=0, acc_out=0, acc_ovf=0, in_ready=1. A following full sum of 8×1 gives acc_out=8 (no leftover from the aborted beats).
- Basic sum: 8 back-to-back beats of 1,2,...,8 with acc_ready=1 -> acc_valid high 1 cycle after the 8th beat, acc_out=36, acc_ovf=0. in_ready=0 for exactly 1 cycle, then 1.
- Backpressure: complete a sum of 8×(-15) with acc_ready=0 for 5 cycles -> acc_out=-120 and acc_valid=1 stable throughout, in_ready=0, and in_valid beats are not consumed. Raising acc_ready gives exactly one handshake.
- Signed mix, 16-bit extremes via mult_16_16_top: 4×(32767*32767=1073676289) plus 4×(-32768*32767=-1073709056) -> acc_out=-131068, acc_ovf=0.
- Overflow, ACC_W=34: 8×(-32768*-32768=1073741824).
  - Without MAC_SATURATE_EN: acc_out=-8589934592, acc_ovf=1.
  - With MAC_SATURATE_EN: acc_out=8589934591, acc_ovf=1.
  - Next sum of 8×1: acc_out=8, acc_ovf=0.
- Clear: 3 beats of 100, then in_clr=1 together with in_valid=1 -> beat not accepted. Then 8 beats of 2 -> acc_out=16. in_clr asserted in OUT -> acc_valid drops on the next edge with no handshake.
